i2c_slave_core: RTL

I2C_SLAVE_CORE -- requirements
Module: i2c_slave_core

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_sync_filter.sv | 81 ++++++++
 rtl/i2c_slave_core.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: widths, R/W bit encodings, FSM state enum
// and a 3-input majority helper used by the optional glitch filter.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WR_BYTE   = 3'd3,
        WR_ACK    = 3'd4,
        RD_BYTE   = 3'd5,
        RD_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_sync_filter.sv
// SCL/SDA front end: two-flop synchronisers, optional 3-sample majority
// filter (enabled by defining I2C_GLITCH_FILTER_EN), SCL edge and
// START/STOP detection. All flops reset to 1 so an idle bus is assumed.
module i2c_sync_filter
    import i2c_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_d;
    logic       r_sda_d;
    logic       w_scl;
    logic       w_sda;

    // Two-flop synchronisers for the asynchronous bus lines
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] r_scl_hist;
    logic [1:0] r_sda_hist;
    logic       r_scl_filt;
    logic       r_sda_filt;

    // Majority of the current and two previous samples; a 1-clk pulse never wins
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_hist <= '1;
            r_sda_hist <= '1;
            r_scl_filt <= 1'b1;
            r_sda_filt <= 1'b1;
        end else begin
            r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
            r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
            r_scl_filt <= maj3(r_scl_sync[1], r_scl_hist[0], r_scl_hist[1]);
            r_sda_filt <= maj3(r_sda_sync[1], r_sda_hist[0], r_sda_hist[1]);
        end
    end

    assign w_scl = r_scl_filt;
    assign w_sda = r_sda_filt;
`else
    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];
`endif

    // Previous-cycle copies for edge and START/STOP detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_d;
    assign o_scl_fall = ~w_scl & r_scl_d;
    assign o_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign o_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule

// File: rtl/i2c_slave_core.sv
// I2C slave protocol engine: address match, write strobes, read requests
// and open-drain SDA control. Optional input glitch filter is selected by
// defining I2C_GLITCH_FILTER_EN (handled inside i2c_sync_filter).
module i2c_slave_core
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic                  wr_valid,
    output logic [I2C_BYTE_W-1:0] wr_data,
    output logic                  wr_first,
    output logic                  rd_req,
    input  logic [I2C_BYTE_W-1:0] rd_data,
    output logic                  busy
);

    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    i2c_sync_filter u_sync (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_scl      (scl_i),
        .i_sda      (sda_i),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    state_t                r_state,      w_state_nxt;
    logic [3:0]            r_bitcnt,     w_bitcnt_nxt;
    logic [I2C_BYTE_W-1:0] r_shift,      w_shift_nxt;
    logic [I2C_BYTE_W-1:0] r_tx,         w_tx_nxt;
    logic [I2C_BYTE_W-1:0] r_wr_data,    w_wr_data_nxt;
    logic                  r_rw,         w_rw_nxt;
    logic                  r_first_pend, w_first_pend_nxt;
    logic                  r_mack,       w_mack_nxt;
    logic                  r_sda_oe,     w_sda_oe_nxt;
    logic                  r_wr_valid,   w_wr_valid_nxt;
    logic                  r_wr_first,   w_wr_first_nxt;
    logic                  r_rd_req,     w_rd_req_nxt;
    logic                  r_busy,       w_busy_nxt;
    logic                  r_load;

    // State and datapath registers; r_load marks the cycle rd_data is valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_tx         <= '0;
            r_wr_data    <= '0;
            r_rw         <= 1'b0;
            r_first_pend <= 1'b0;
            r_mack       <= 1'b0;
            r_sda_oe     <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_wr_first   <= 1'b0;
            r_rd_req     <= 1'b0;
            r_busy       <= 1'b0;
            r_load       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_shift      <= w_shift_nxt;
            r_tx         <= w_tx_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_rw         <= w_rw_nxt;
            r_first_pend <= w_first_pend_nxt;
            r_mack       <= w_mack_nxt;
            r_sda_oe     <= w_sda_oe_nxt;
            r_wr_valid   <= w_wr_valid_nxt;
            r_wr_first   <= w_wr_first_nxt;
            r_rd_req     <= w_rd_req_nxt;
            r_busy       <= w_busy_nxt;
            r_load       <= r_rd_req;
        end
    end

    // Next-state and output logic; START/STOP override any coincident SCL edge
    always_comb begin
        w_state_nxt      = r_state;
        w_bitcnt_nxt     = r_bitcnt;
        w_shift_nxt      = r_shift;
        w_tx_nxt         = r_tx;
        w_wr_data_nxt    = r_wr_data;
        w_rw_nxt         = r_rw;
        w_first_pend_nxt = r_first_pend;
        w_mack_nxt       = r_mack;
        w_sda_oe_nxt     = r_sda_oe;
        w_wr_valid_nxt   = 1'b0;
        w_wr_first_nxt   = r_wr_first;
        w_rd_req_nxt     = 1'b0;
        w_busy_nxt       = r_busy;

        if (w_start) begin
            w_state_nxt  = ADDR;
            w_bitcnt_nxt = '0;
            w_sda_oe_nxt = 1'b0;
            w_mack_nxt   = 1'b0;
        end else if (w_stop) begin
            w_state_nxt  = IDLE;
            w_bitcnt_nxt = '0;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE, WAIT_STOP: begin
                end
                ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt  = {r_shift[I2C_BYTE_W-2:0], w_sda};
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                    end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                        w_bitcnt_nxt = '0;
                        if (r_shift[I2C_BYTE_W-1:1] == SLAVE_ADDR) begin
                            w_state_nxt  = ADDR_ACK;
                            w_sda_oe_nxt = 1'b1;
                            w_busy_nxt   = 1'b1;
                            w_rw_nxt     = r_shift[0];
                        end else begin
                            w_state_nxt  = WAIT_STOP;
                            w_sda_oe_nxt = 1'b0;
                            w_busy_nxt   = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                        w_bitcnt_nxt = '0;
                        if (r_rw == RW_READ) begin
                            w_state_nxt  = RD_BYTE;
                            w_rd_req_nxt = 1'b1;
                        end else begin
                            w_state_nxt      = WR_BYTE;
                            w_first_pend_nxt = 1'b1;
                        end
                    end
                end
                WR_BYTE: begin
                    if (w_scl_rise) begin
                        w_shift_nxt  = {r_shift[I2C_BYTE_W-2:0], w_sda};
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                    end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                        w_wr_valid_nxt   = 1'b1;
                        w_wr_data_nxt    = r_shift;
                        w_wr_first_nxt   = r_first_pend;
                        w_first_pend_nxt = 1'b0;
                        w_sda_oe_nxt     = 1'b1;
                        w_bitcnt_nxt     = '0;
                        w_state_nxt      = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                        w_state_nxt  = WR_BYTE;
                    end
                end
                RD_BYTE: begin
                    // Data arrives two cycles after the SCL fall that raised rd_req;
                    // SCL is still low then, so the MSB is set up in time.
                    if (r_load) begin
                        w_tx_nxt     = rd_data;
                        w_sda_oe_nxt = ~rd_data[I2C_BYTE_W-1];
                    end else if (w_scl_fall) begin
                        if (r_bitcnt == 4'd7) begin
                            w_sda_oe_nxt = 1'b0;
                            w_bitcnt_nxt = '0;
                            w_mack_nxt   = 1'b0;
                            w_state_nxt  = RD_ACK;
                        end else begin
                            w_tx_nxt     = {r_tx[I2C_BYTE_W-2:0], 1'b0};
                            w_sda_oe_nxt = ~r_tx[I2C_BYTE_W-2];
                            w_bitcnt_nxt = r_bitcnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda) w_state_nxt = WAIT_STOP;
                        else       w_mack_nxt  = 1'b1;
                    end else if (w_scl_fall && r_mack) begin
                        w_rd_req_nxt = 1'b1;
                        w_mack_nxt   = 1'b0;
                        w_state_nxt  = RD_BYTE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign sda_oe   = r_sda_oe;
    assign wr_valid = r_wr_valid;
    assign wr_data  = r_wr_data;
    assign wr_first = r_wr_first;
    assign rd_req   = r_rd_req;
    assign busy     = r_busy;

endmodule
